// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the push-button conditioner.
//   deb_state_t : per-channel debounce FSM state encoding
//   BTN_*       : bit index of each board button inside btn_in/btn_* vectors
//   max_u       : elaboration helper used to size counters
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } deb_state_t;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel.
//   2-FF synchronizer -> debounce FSM with saturating counter -> registered
//   level / press / release. Optional auto-repeat (macro BTN_AUTOREPEAT_EN)
//   adds extra press pulses while the button stays accepted-high.
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  asynchronous active-high reset
//   btn        in  raw asynchronous button pin
//   level      out debounced level
//   press      out one-cycle pulse on accepted press (or auto-repeat)
//   rel        out one-cycle pulse on accepted release
//   press_next out combinational value that press takes on the next edge
//                  (lets the top register any_press with no extra latency)
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_next
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic          sync1, sync2;
    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt;
    logic          rel_nxt;
    logic          accept_press;
    logic          enter_high;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        level_nxt    = level;
        rel_nxt      = 1'b0;
        accept_press = 1'b0;
        enter_high   = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = HIGH;
                    cnt_nxt      = '0;
                    level_nxt    = 1'b1;
                    accept_press = 1'b1;
                    enter_high   = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_nxt  = HIGH;
                    cnt_nxt    = '0;
                    enter_high = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned   RW       = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;
    logic          rpt_phase, rpt_phase_nxt;  // 0: waiting first delay, 1: periodic
    logic          rpt_fire;

    // Counter only advances while staying in HIGH; the leaving edge and the
    // WAIT_LOW dwell never fire, and re-entry restarts the delay phase.
    always_comb begin
        rpt_cnt_nxt   = rpt_cnt;
        rpt_phase_nxt = rpt_phase;
        rpt_fire      = 1'b0;
        if (enter_high) begin
            rpt_cnt_nxt   = '0;
            rpt_phase_nxt = 1'b0;
        end else if (state == HIGH && sync2) begin
            if (rpt_cnt == (rpt_phase ? PER_LAST : DLY_LAST)) begin
                rpt_fire      = 1'b1;
                rpt_cnt_nxt   = '0;
                rpt_phase_nxt = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_phase <= rpt_phase_nxt;
        end
    end

    assign press_next = accept_press | rpt_fire;
`else
    assign press_next = accept_press;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_next;
            rel   <= rel_nxt;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions NUM_BTN raw push-buttons into clean clk-domain
// level and press/release pulses. Single clock, no derived clocks.
// Optional auto-repeat of press pulses: define BTN_AUTOREPEAT_EN.
// Ports:
//   clk         in  system clock (100 MHz), rising edge
//   reset       in  asynchronous active-high reset
//   btn_in      in  [NUM_BTN] raw button pins, {D,R,L,U,C} for NUM_BTN=5
//   btn_level   out [NUM_BTN] debounced level
//   btn_press   out [NUM_BTN] one-cycle press (and auto-repeat) pulses
//   btn_release out [NUM_BTN] one-cycle release pulses
//   any_press   out OR of btn_press, aligned with btn_press
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    logic [NUM_BTN-1:0] press_next;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn        (btn_in[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .rel        (btn_release[i]),
            .press_next (press_next[i])
        );
    end

    // Registered from the channels' next-press values so it rises in the
    // same cycle as btn_press rather than one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: directed scenarios plus randomized button
// activity, checked every cycle against a run-length reference model.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, btn_press, btn_release;
    logic         any_press;

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN         (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: two-stage input delay, then a channel's accepted level
    // flips once D consecutive delayed samples disagree with it. Repeat pulses
    // are timed from the last edge the channel became stably high.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_rel = '0;
    logic         m_any = 1'b0;
    logic [N-1:0] m_samp;
    int           m_run [N];
    int           m_hold[N];
    bit           m_was_waiting;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_hold[i] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_run[i]  = 0;
                    m_hold[i] = 0;
                end
            end else begin
                m_samp  = m_s2;
                m_s2    = m_s1;
                m_s1    = btn_in;
                m_press = '0;
                m_rel   = '0;
                for (int i = 0; i < N; i++) begin
                    m_was_waiting = (m_run[i] != 0);
                    if (m_samp[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == D) begin
                            m_level[i] = m_samp[i];
                            m_run[i]   = 0;
                            m_hold[i]  = 0;
                            if (m_samp[i]) m_press[i] = 1'b1;
                            else           m_rel[i]   = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                        if (m_level[i]) begin
                            if (m_was_waiting) begin
                                m_hold[i] = 0;
                            end else begin
                                m_hold[i]++;
`ifdef BTN_AUTOREPEAT_EN
                                if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0))
                                    m_press[i] = 1'b1;
`endif
                            end
                        end
                    end
                end
                m_any = |m_press;
            end
        end
    end

    // Per-cycle comparison against the model and pulse counters.
    int cnt_press[N];
    int cnt_rel[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0;
            cnt_rel[i]   = 0;
        end
        forever begin
            @(negedge clk);
            check_eq("level",   btn_level,   m_level);
            check_eq("press",   btn_press,   m_press);
            check_eq("release", btn_release, m_rel);
            check_eq("any",     any_press,   m_any);
            check_eq("press_and_release", btn_press & btn_release, '0);
            for (int i = 0; i < N; i++) begin
                if (btn_press[i])   cnt_press[i]++;
                if (btn_release[i]) cnt_rel[i]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    int rem[N];
    int exp_rpt;

    initial begin
        #1 reset = 1'b1;
        tick(2);
        check_eq("rst_level",   btn_level,   '0);
        check_eq("rst_press",   btn_press,   '0);
        check_eq("rst_release", btn_release, '0);
        check_eq("rst_any",     any_press,   '0);
        reset = 1'b0;
        tick(3);

        // clean press on C
        btn_in[0] = 1'b1;
        tick(5);
        check_eq("clean_pre_press", btn_press[0], 1'b0);
        tick(1);
        check_eq("clean_press", btn_press[0], 1'b1);
        check_eq("clean_level", btn_level[0], 1'b1);
        check_eq("clean_any",   any_press,    1'b1);
        tick(1);
        check_eq("clean_press_low", btn_press[0], 1'b0);
        btn_in[0] = 1'b0;
        tick(8);

        // bounce reject on L
        base = cnt_press[2];
        btn_in[2] = 1'b1;
        tick(3);
        btn_in[2] = 1'b0;
        tick(8);
        check_eq("bounce_no_press", cnt_press[2] - base, 0);
        check_eq("bounce_level",    btn_level[2], 1'b0);
        btn_in[2] = 1'b1;
        tick(6);
        check_eq("bounce_final_press", btn_press[2], 1'b1);
        tick(1);

        // release with bounce on R
        btn_in[3] = 1'b1;
        tick(8);
        base = cnt_rel[3];
        btn_in[3] = 1'b0;
        tick(2);
        btn_in[3] = 1'b1;
        tick(1);
        btn_in[3] = 1'b0;
        tick(5);
        check_eq("rel_glitch_none", cnt_rel[3] - base, 0);
        tick(1);
        check_eq("rel_pulse", btn_release[3], 1'b1);
        check_eq("rel_level", btn_level[3],   1'b0);
        btn_in = '0;
        tick(8);

        // simultaneous presses
        btn_in = 5'b10101;
        tick(6);
        check_eq("simul_press", btn_press, 5'b10101);
        check_eq("simul_any",   any_press, 1'b1);
        tick(1);
        check_eq("simul_any_low", any_press, 1'b0);
        btn_in = '0;
        tick(8);

        // async reset mid-debounce while another channel is accepted high
        btn_in[0] = 1'b1;
        tick(8);
        btn_in[4] = 1'b1;
        tick(4);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_level", btn_level, '0);
        check_eq("arst_press", btn_press, '0);
        @(negedge clk);
        reset = 1'b0;
        tick(6);
        check_eq("arst_held_press", btn_press, 5'b10001);
        btn_in = '0;
        tick(8);

        // auto-repeat on U: held through 20 edges after the accepted press
        base = cnt_press[1];
        btn_in[1] = 1'b1;
        tick(6);
        tick(18);
        btn_in[1] = 1'b0;
        tick(8);
`ifdef BTN_AUTOREPEAT_EN
        exp_rpt = 5;
`else
        exp_rpt = 1;
`endif
        check_eq("repeat_count", cnt_press[1] - base, exp_rpt);

        // randomized activity with occasional asynchronous resets
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    btn_in[i] = ~btn_in[i];
                    rem[i] = (i == 1) ? $urandom_range(1, 30) : $urandom_range(1, 12);
                end else begin
                    rem[i]--;
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                #1;
                check_eq("rand_arst_level", btn_level, '0);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                tick(1);
            end
        end
        btn_in = '0;
        tick(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
